// File: rtl/q_learn_pkg.sv
// Shared constants and helpers for the Q-learning update datapath.
// Default widths, saturation limits and the signed clamp function.
package q_learn_pkg;

    localparam int Q_W     = 16;
    localparam int Q_SW    = 4;
    localparam int Q_N_ACT = 9;
    localparam int Q_TAG_W = 8;

    // Working width used by the generic clamp helper
    localparam int CLAMP_W = 64;

    localparam logic signed [Q_W-1:0] Q_MAX = {1'b0, {(Q_W-1){1'b1}}};
    localparam logic signed [Q_W-1:0] Q_MIN = {1'b1, {(Q_W-1){1'b0}}};

    typedef struct packed {
        logic signed [CLAMP_W-1:0] val;
        logic                      sat;
    } clamp_t;

    // Clamp a wide signed value into the signed range of a w-bit word
    function automatic clamp_t sat_clamp(
        input logic signed [CLAMP_W-1:0] v,
        input int unsigned               w
    );
        clamp_t                    r;
        logic signed [CLAMP_W-1:0] hi;
        logic signed [CLAMP_W-1:0] lo;
        hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (w - 1));
        r.val = v;
        r.sat = 1'b0;
        if (v > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end else if (v < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/q_update_pipe_if.sv
// Upstream and downstream handshake bundle of the Q-value updater.
// The master side feeds updates and drains results.
interface q_update_if
    import q_learn_pkg::*;
#(
    parameter int W     = Q_W,
    parameter int SW    = Q_SW,
    parameter int N_ACT = Q_N_ACT,
    parameter int TAG_W = Q_TAG_W
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in_q;
    logic [N_ACT*W-1:0]   in_next_q;
    logic [W-1:0]         in_reward;
    logic [SW-1:0]        in_gamma;
    logic [SW-1:0]        in_alfa;
    logic                 in_terminal;
    logic [TAG_W-1:0]     in_tag;

    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_q_new;
    logic [W-1:0]         out_max_q;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_sat;

    modport master (
        output in_valid, in_q, in_next_q, in_reward,
        output in_gamma, in_alfa, in_terminal, in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid, out_q_new, out_max_q, out_tag, out_sat
    );

    modport slave (
        input  in_valid, in_q, in_next_q, in_reward,
        input  in_gamma, in_alfa, in_terminal, in_tag,
        input  out_ready,
        output in_ready,
        output out_valid, out_q_new, out_max_q, out_tag, out_sat
    );

endinterface

// File: rtl/q_update_pipe_shifter.sv
// Parametrised arithmetic right shifter.
// Shift amounts of W or more saturate to the sign fill.
module barrel_shifter_param #(
    parameter int W  = 16,
    parameter int SW = 4
) (
    input  logic signed [W-1:0]  din,
    input  logic        [SW-1:0] shamt,
    output logic signed [W-1:0]  dout
);

    // Sign-filling shift with an explicit over-range case
    always_comb begin
        dout = din >>> shamt;
        if (32'(shamt) >= W) begin
            dout = {W{din[W-1]}};
        end
    end

endmodule

// File: rtl/q_update_pipe.sv
// Three-stage saturating Q-value updater with valid/ready flow control.
// S1 max/discount, S2 TD error, S3 learning-rate step and write value.
module q_update_pipe
    import q_learn_pkg::*;
#(
    parameter int W     = Q_W,
    parameter int SW    = Q_SW,
    parameter int N_ACT = Q_N_ACT,
    parameter int TAG_W = Q_TAG_W
) (
    input logic       clk,
    input logic       rst_n,
    q_update_if.slave bus
);

    logic adv1;
    logic adv2;
    logic adv3;

    logic v1;
    logic v2;
    logic v3;

    logic signed [W-1:0] cand;
    logic signed [W-1:0] max_c;
    logic signed [W-1:0] max_eff;
    logic signed [W-1:0] g_c;

    logic signed [W-1:0] g1;
    logic signed [W-1:0] max1;
    logic signed [W-1:0] q1;
    logic signed [W-1:0] r1;
    logic [SW-1:0]       alfa1;
    logic [TAG_W-1:0]    tag1;

    logic signed [W+1:0] d_wide;
    clamp_t              d_clamp;

    logic signed [W-1:0] d2;
    logic signed [W-1:0] max2;
    logic signed [W-1:0] q2;
    logic [SW-1:0]       alfa2;
    logic [TAG_W-1:0]    tag2;
    logic                sat2;

    logic signed [W-1:0] a_c;
    logic signed [W:0]   n_wide;
    clamp_t              n_clamp;

    assign adv3 = !v3 || bus.out_ready;
    assign adv2 = !v2 || adv3;
    assign adv1 = !v1 || adv2;

    assign bus.in_ready  = adv1;
    assign bus.out_valid = v3;

    // Signed maximum over the next-state action values
    always_comb begin
        max_c = $signed(bus.in_next_q[W-1:0]);
        cand  = '0;
        for (int i = 1; i < N_ACT; i++) begin
            cand = $signed(bus.in_next_q[i*W +: W]);
            if (cand > max_c) begin
                max_c = cand;
            end
        end
    end

    assign max_eff = bus.in_terminal ? '0 : max_c;

    barrel_shifter_param #(
        .W  (W),
        .SW (SW)
    ) u_gamma_shift (
        .din   (max_eff),
        .shamt (bus.in_gamma),
        .dout  (g_c)
    );

    // S1 register: discounted max plus carried operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            g1    <= '0;
            max1  <= '0;
            q1    <= '0;
            r1    <= '0;
            alfa1 <= '0;
            tag1  <= '0;
        end else if (adv1) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                g1    <= g_c;
                max1  <= max_eff;
                q1    <= $signed(bus.in_q);
                r1    <= $signed(bus.in_reward);
                alfa1 <= bus.in_alfa;
                tag1  <= bus.in_tag;
            end
        end
    end

    // TD error at W+2 bits, then clamped back to W
    always_comb begin
        d_wide  = (W+2)'(r1) + (W+2)'(g1) - (W+2)'(q1);
        d_clamp = sat_clamp(CLAMP_W'(d_wide), W);
    end

    // S2 register: clamped TD error and its clamp flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            d2    <= '0;
            max2  <= '0;
            q2    <= '0;
            alfa2 <= '0;
            tag2  <= '0;
            sat2  <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                d2    <= W'(d_clamp.val);
                max2  <= max1;
                q2    <= q1;
                alfa2 <= alfa1;
                tag2  <= tag1;
                sat2  <= d_clamp.sat;
            end
        end
    end

    barrel_shifter_param #(
        .W  (W),
        .SW (SW)
    ) u_alfa_shift (
        .din   (d2),
        .shamt (alfa2),
        .dout  (a_c)
    );

    // New Q at W+1 bits, then clamped back to W
    always_comb begin
        n_wide  = (W+1)'(q2) + (W+1)'(a_c);
        n_clamp = sat_clamp(CLAMP_W'(n_wide), W);
    end

    // S3 register: result held stable while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3            <= 1'b0;
            bus.out_q_new <= '0;
            bus.out_max_q <= '0;
            bus.out_tag   <= '0;
            bus.out_sat   <= 1'b0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2) begin
                bus.out_q_new <= W'(n_clamp.val);
                bus.out_max_q <= max2;
                bus.out_tag   <= tag2;
                bus.out_sat   <= sat2 | n_clamp.sat;
            end
        end
    end

endmodule

// File: tb/tb_q_update_pipe.sv
// Directed-vector bench for the pipelined Q-value updater.
// Each scenario task drives stimulus and checks its own results.
module tb_q_update_pipe;

    localparam int W  = 16;
    localparam int SW = 4;
    localparam int N  = 9;
    localparam int TW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    int r_q;
    int r_max;
    int r_tag;
    int r_sat;
    int r_lat;

    always #5 clk = ~clk;

    q_update_if #(.W(W), .SW(SW), .N_ACT(N), .TAG_W(TW)) bus ();

    q_update_pipe #(
        .W     (W),
        .SW    (SW),
        .N_ACT (N),
        .TAG_W (TW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic set_in(input int q, input int n0, input int n1,
                          input int n2, input int nr, input int rw,
                          input int gm, input int al, input int term,
                          input int tag);
        bus.in_q = 16'(q);
        for (int i = 0; i < N; i++) begin
            bus.in_next_q[i*W +: W] = 16'(nr);
        end
        bus.in_next_q[0*W +: W] = 16'(n0);
        bus.in_next_q[1*W +: W] = 16'(n1);
        bus.in_next_q[2*W +: W] = 16'(n2);
        bus.in_reward   = 16'(rw);
        bus.in_gamma    = 4'(gm);
        bus.in_alfa     = 4'(al);
        bus.in_terminal = 1'(term);
        bus.in_tag      = 8'(tag);
    endtask

    task automatic run_one();
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        r_lat = 1;
        while (bus.out_valid !== 1'b1 && r_lat < 10) begin
            @(posedge clk);
            #1;
            r_lat++;
        end
        r_q   = $signed(bus.out_q_new);
        r_max = $signed(bus.out_max_q);
        r_tag = int'(bus.out_tag);
        r_sat = int'(bus.out_sat);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #12;
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid got %0b want 0", bus.out_valid);
        end
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got %0b want 1", bus.in_ready);
        end
        n_vec++;
        if (bus.out_q_new !== 16'h0 || bus.out_max_q !== 16'h0 ||
            bus.out_tag !== 8'h0 || bus.out_sat !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs got q=%h m=%h t=%h s=%b want 0",
                     bus.out_q_new, bus.out_max_q, bus.out_tag, bus.out_sat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        set_in(100, 40, 200, -5, 0, 50, 1, 2, 0, 8'h11);
        run_one();
        n_vec++;
        if (r_lat !== 3) begin
            n_err++;
            $display("FAIL basic_latency got %0d want 3", r_lat);
        end
        n_vec++;
        if (r_q !== 112) begin
            n_err++;
            $display("FAIL basic_q got %0d want 112", r_q);
        end
        n_vec++;
        if (r_max !== 200 || r_sat !== 0 || r_tag !== 8'h11) begin
            n_err++;
            $display("FAIL basic_aux got max=%0d sat=%0d tag=%0h want 200 0 11",
                     r_max, r_sat, r_tag);
        end
    endtask

    task automatic test_terminal();
        set_in(-40, 300, 300, 300, 300, -100, 0, 1, 1, 8'h22);
        run_one();
        n_vec++;
        if (r_q !== -70 || r_max !== 0 || r_sat !== 0) begin
            n_err++;
            $display("FAIL terminal got q=%0d max=%0d sat=%0d want -70 0 0",
                     r_q, r_max, r_sat);
        end
    endtask

    task automatic test_saturation();
        set_in(32000, 32767, 32767, 32767, 32767, 32767, 0, 0, 0, 8'h33);
        run_one();
        n_vec++;
        if (r_q !== 32767 || r_sat !== 1 || r_max !== 32767) begin
            n_err++;
            $display("FAIL sat_pos got q=%0d sat=%0d max=%0d want 32767 1 32767",
                     r_q, r_sat, r_max);
        end
        set_in(-32000, -32768, -32768, -32768, -32768, -32768, 0, 0, 0, 8'h44);
        run_one();
        n_vec++;
        if (r_q !== -32768 || r_sat !== 1 || r_max !== -32768) begin
            n_err++;
            $display("FAIL sat_neg got q=%0d sat=%0d max=%0d want -32768 1 -32768",
                     r_q, r_sat, r_max);
        end
    endtask

    task automatic test_large_shift();
        set_in(0, -7, -7, -7, -7, 6, 15, 15, 0, 8'h55);
        run_one();
        n_vec++;
        if (r_q !== 0 || r_max !== -7 || r_sat !== 0) begin
            n_err++;
            $display("FAIL shift_alfa15 got q=%0d max=%0d sat=%0d want 0 -7 0",
                     r_q, r_max, r_sat);
        end
        set_in(0, -7, -7, -7, -7, 6, 15, 0, 0, 8'h56);
        run_one();
        n_vec++;
        if (r_q !== 5) begin
            n_err++;
            $display("FAIL shift_gamma15 got q=%0d want 5", r_q);
        end
        set_in(10, 0, 0, 0, 0, 5, 3, 15, 0, 8'h57);
        run_one();
        n_vec++;
        if (r_q !== 9) begin
            n_err++;
            $display("FAIL shift_neg_alfa15 got q=%0d want 9", r_q);
        end
    endtask

    task automatic test_back_to_back();
        int exp_q [6] = '{10, 21, 31, 42, 52, 63};
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int blk = -1;
        bit acc;
        bit held = 0;
        logic [W-1:0]  h_q;
        logic [TW-1:0] h_tag;
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            bus.out_ready = (cyc >= 8);
            if (sent < 6) begin
                set_in(10*(sent+1), 20*(sent+1), 0, 0, 0, sent+1, 1, 1, 0,
                       sent+1);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            acc = bus.in_valid && bus.in_ready;
            if (!bus.in_ready && blk < 0) blk = sent;
            if (bus.out_valid && !bus.out_ready) begin
                if (held) begin
                    n_vec++;
                    if (bus.out_q_new !== h_q || bus.out_tag !== h_tag) begin
                        n_err++;
                        $display("FAIL stall_stable got q=%h t=%h want q=%h t=%h",
                                 bus.out_q_new, bus.out_tag, h_q, h_tag);
                    end
                end
                held  = 1;
                h_q   = bus.out_q_new;
                h_tag = bus.out_tag;
            end
            if (bus.out_valid && bus.out_ready) begin
                n_vec++;
                if (int'(bus.out_tag) !== got + 1 ||
                    $signed(bus.out_q_new) !== exp_q[got] ||
                    $signed(bus.out_max_q) !== 20*(got+1)) begin
                    n_err++;
                    $display("FAIL b2b_out%0d got t=%0d q=%0d m=%0d want t=%0d q=%0d m=%0d",
                             got, bus.out_tag, $signed(bus.out_q_new),
                             $signed(bus.out_max_q), got+1, exp_q[got],
                             20*(got+1));
                end
                got++;
                held = 0;
            end
            @(posedge clk);
            if (acc) sent++;
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_vec++;
        if (got !== 6) begin
            n_err++;
            $display("FAIL b2b_count got %0d want 6", got);
        end
        n_vec++;
        if (blk !== 3) begin
            n_err++;
            $display("FAIL b2b_block_after got %0d want 3", blk);
        end
    endtask

    task automatic test_reset_mid();
        bit stale = 0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            set_in(1, 2, 0, 0, 0, 1, 0, 0, 0, 8'hA0 + t);
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        n_vec++;
        if (bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre got out_valid=%0b want 1", bus.out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.out_tag !== 8'h0 ||
            bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_async got v=%0b t=%h r=%0b want 0 00 1",
                     bus.out_valid, bus.out_tag, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) stale = 1;
        end
        n_vec++;
        if (stale) begin
            n_err++;
            $display("FAIL rstmid_stale got stale result want none");
        end
        set_in(100, 40, 200, -5, 0, 50, 1, 2, 0, 8'h77);
        run_one();
        n_vec++;
        if (r_q !== 112 || r_tag !== 8'h77 || r_lat !== 3) begin
            n_err++;
            $display("FAIL rstmid_after got q=%0d t=%0h lat=%0d want 112 77 3",
                     r_q, r_tag, r_lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_terminal();
        test_saturation();
        test_large_shift();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/q_update_pipe.md
Name: q_update_pipe

Overview:
Parametrised, pipelined successor of the combinational Q-value updater: computes Q_new = Q + ((reward + (maxQ >>> gamma) - Q) >>> alfa) with signed saturating arithmetic. Adds an in-block max reduction over N_ACT next-state action values, a terminal-state mode, and a tag pass-through. Uses valid/ready handshakes on both sides, with throughput of 1 update/cycle. Sits between the Q-table read port and the Q-table write-back in the tic-tac-toe learning agent.

Parameters:
W, 16, data width of all Q/reward values (signed two's complement)
SW, 4, width of gamma/alfa shift controls
N_ACT, 9, number of next-state action values reduced to maxQ (one per board cell)
TAG_W, 8, width of opaque tag (state/action index) carried with each update

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept input this cycle
in_q  in  W  current Q(s,a), signed
in_next_q  in  N_ACT*W  Q(s',a') values; action i at bits [i*W +: W], signed
in_reward  in  W  reward, signed
in_gamma  in  SW  discount as right-shift amount
in_alfa  in  SW  learning rate as right-shift amount
in_terminal  in  1  1 = s' terminal; maxQ forced to 0
in_tag  in  TAG_W  passed through unchanged
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_q_new  out  W  updated Q, signed, saturated
out_max_q  out  W  maxQ used (debug/verification tap)
out_tag  out  TAG_W  tag of this result
out_sat  out  1  1 if any clamp occurred in this update

Behaviour:
- Reset is asynchronous and active-low (rst_n=0): all stage-valid flags, out_valid, out_q_new, out_max_q, out_tag and out_sat are cleared to 0 immediately. In-flight transactions are discarded.
- Pipeline has 3 registered stages, so latency is 3 cycles from the accepting edge to out_valid with no stall.
  - S1: signed max over N_ACT values (ties are irrelevant because values are equal); force to 0 if in_terminal; g = maxQ >>> in_gamma.
  - S2: d = reward + g - Q computed at W+2 bits, then clamped to [-2^(W-1), 2^(W-1)-1].
  - S3: a = d >>> in_alfa; n = Q + a computed at W+1 bits, then clamped. gamma/alfa/Q/tag are carried alongside the data.
- Shifts are arithmetic (sign fill). A shift amount >= W yields 0 for non-negative values and -1 for negative values.
- out_sat = OR of the S2 and S3 clamp events for that transaction.
- Handshake:
  - An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
  - A stage advances when it is empty or the stage after it advances. in_ready = S1 empty OR S1 advancing (combinational from out_ready through the stage chain; no skid buffer).
  - Output data must hold stable while out_valid && !out_ready.
- No transaction is dropped or duplicated, and order is preserved. Bubbles collapse when the output is stalled.
- in_* values are don't-care when in_valid=0, and the pipeline ignores them.

Decomposition:
- Shared package q_learn_pkg holds: the default W/SW/N_ACT/TAG_W values, the signed saturation limit constants, and a sat_clamp function (wide value to W bits plus a clamp flag).
- Sub-module: barrel_shifter_param (parameters W, SW; arithmetic right shift) — the parametrised replacement for the fixed 16-bit shifter. Instantiated twice (S1 and S3).
- The max reduction is an inline loop, not a separate module.

Test Plan:
- Basic: W=16, Q=100, next_q={40,200,-5,0,...0}, reward=50, gamma=1, alfa=2, terminal=0 -> 3 cycles later out_q_new=112, out_max_q=200, out_sat=0.
- Terminal and negative values: Q=-40, next_q all 300, reward=-100, gamma=0, alfa=1, terminal=1 -> maxQ=0, d=-60, a=-30, out_q_new=-70.
- Saturation: Q=32000, next_q max 32767, reward=32767, gamma=0, alfa=0 -> d clamps to 32767, n clamps to 32767, out_sat=1. Also check the negative mirror: result -32768, out_sat=1.
- Backpressure: stream 6 back-to-back inputs with tags 1..6, hold out_ready=0 for 5 cycles, then release -> in_ready falls after 3 accepts, no loss, tags emerge 1..6 in order, output data stable while stalled.
- Large shift: gamma=15 on maxQ=-7 -> g=-1; alfa=15 on d=5 -> a=0.
- Reset mid-operation: assert rst_n=0 asynchronously with 3 transactions in flight -> out_valid=0 immediately with no clock edge needed, and no stale result appears after rst_n returns to 1.
